// File: rtl/uart_tx_packet.sv
// UART packet transmitter: push FIFO, configurable parity/stop bits and an
// optional CRC character appended after the last character of each packet.
`timescale 1ns/1ps
module uart_tx_packet #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] CRC_POLY   = 'h07
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          last_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          stop2_i,
  input  logic                          crc_en_i,
  input  logic                          trigger_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          tx_int_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  // FIFO entries are {last, data}
  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       level_reg;
  logic              fifo_empty, fifo_full, push, pop;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  state_t            state_reg, state_next;
  logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              par_en_reg, par_en_next;
  logic              par_bit_reg, par_bit_next;
  logic              stop2_reg, stop2_next;
  logic [DATA_W-1:0] crc_reg, crc_next;
  logic [DATA_W-1:0] crc_tx_reg, crc_tx_next;
  logic              crc_pending_reg, crc_pending_next;
  logic              tx_reg, tx_next;
  logic              tx_int_reg;
  logic              load, eof, load_cond;
  logic [DATA_W-1:0] load_data, crc_upd;

  function automatic logic [DATA_W-1:0] crc_step(input logic [DATA_W-1:0] crc,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] c;
    logic              fb;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[DATA_W-1] ^ d[i];
      c  = {c[DATA_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == (AW+1)'(FIFO_DEPTH));
  assign push       = valid_i && !fifo_full;
  assign head_data  = fifo_mem[rd_ptr_reg][DATA_W-1:0];
  assign head_last  = fifo_mem[rd_ptr_reg][DATA_W];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= {last_i, data_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    par_en_next      = par_en_reg;
    par_bit_next     = par_bit_reg;
    stop2_next       = stop2_reg;
    crc_next         = crc_reg;
    crc_tx_next      = crc_tx_reg;
    crc_pending_next = crc_pending_reg;
    load             = 1'b0;
    eof              = 1'b0;
    load_data        = '0;
    crc_upd          = '0;
    load_cond        = !fifo_empty || crc_pending_reg;

    if (trigger_i) begin
      case (state_reg)
        S_IDLE:   if (load_cond) load = 1'b1;
        S_START: begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
        end
        S_DATA: begin
          if (bit_cnt_reg == CW'(DATA_W - 1)) begin
            state_next = par_en_reg ? S_PARITY : S_STOP1;
          end else begin
            bit_cnt_next = bit_cnt_reg + CW'(1);
            shift_next   = shift_reg >> 1;
          end
        end
        S_PARITY: state_next = S_STOP1;
        S_STOP1:  if (stop2_reg) state_next = S_STOP2; else eof = 1'b1;
        S_STOP2:  eof = 1'b1;
        default:  state_next = S_IDLE;
      endcase
    end

    // End of frame chains straight into the next frame when work is queued
    if (eof) begin
      if (load_cond) load = 1'b1;
      else           state_next = S_IDLE;
    end

    pop = load && !crc_pending_reg;

    if (load) begin
      load_data        = crc_pending_reg ? crc_tx_reg : head_data;
      state_next       = S_START;
      shift_next       = load_data;
      par_en_next      = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
      par_bit_next     = (^load_data) ^ (parity_mode_i == 2'b10);
      stop2_next       = stop2_i;
      crc_pending_next = 1'b0;
    end

    if (pop) begin
      crc_upd = crc_step(crc_reg, head_data);
      if (head_last) begin
        crc_next = '0;
        if (crc_en_i) begin
          crc_tx_next      = crc_upd;
          crc_pending_next = 1'b1;
        end
      end else begin
        crc_next = crc_upd;
      end
    end

    case (state_reg)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_reg[0];
      S_PARITY: tx_next = par_bit_reg;
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg       <= S_IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      par_en_reg      <= 1'b0;
      par_bit_reg     <= 1'b0;
      stop2_reg       <= 1'b0;
      crc_reg         <= '0;
      crc_tx_reg      <= '0;
      crc_pending_reg <= 1'b0;
      tx_reg          <= 1'b1;
      tx_int_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      par_en_reg      <= par_en_next;
      par_bit_reg     <= par_bit_next;
      stop2_reg       <= stop2_next;
      crc_reg         <= crc_next;
      crc_tx_reg      <= crc_tx_next;
      crc_pending_reg <= crc_pending_next;
      tx_reg          <= tx_next;
      tx_int_reg      <= eof;
    end
  end

  assign ready_o      = !fifo_full;
  assign tx_o         = tx_reg;
  assign tx_int_o     = tx_int_reg;
  assign busy_o       = (state_reg != S_IDLE) || !fifo_empty || crc_pending_reg;
  assign fifo_level_o = level_reg;

endmodule

// File: doc/uart_tx_packet.md
Name: uart_tx_packet

Overview:
Parametrised successor to the single-byte UART transmitter. Accepts characters through a valid/ready push interface into an internal FIFO. Serialises each character as a UART frame with a configurable data width, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. When CRC is enabled, it appends a CRC character after the character flagged as the last of a packet. It sits between the packet producer and the serial pin and uses the shared baud tick (trigger_i).

Parameters:
DATA_W, 8, data bits per character (5..8); CRC width equals DATA_W
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2)
CRC_POLY, 8'h07, CRC polynomial (DATA_W bits, implicit top bit); init all-zeros, MSB-first, no reflection, no final XOR

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
data_i  in  DATA_W  character to push
last_i  in  1  character is the last of a packet
valid_i  in  1  push request
ready_o  out  1  FIFO not full; a push happens when valid_i && ready_o
parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2_i  in  1  1 = two stop bits
crc_en_i  in  1  append CRC after the last character
trigger_i  in  1  baud tick, one-cycle pulse, one per bit period
tx_o  out  1  serial line, idle high, registered
busy_o  out  1  FSM not in IDLE, FIFO non-empty, or CRC character pending
tx_int_o  out  1  one-cycle pulse when a frame's final stop bit ends
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_i low, asynchronous): tx_o=1, ready_o=1, busy_o=0, tx_int_o=0, fifo_level_o=0. FSM goes to IDLE, FIFO is flushed, CRC register is cleared, crc_pending=0. Applies immediately, including mid-frame; the line returns high with no stop bit.
- FIFO: each entry is {last, data}. Push and pop in the same cycle leave the level unchanged. When full, ready_o=0 and the push is ignored. Level never exceeds FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. All transitions occur only on cycles with trigger_i=1. tx_o is updated on the cycle after the transition, so each bit lasts exactly one trigger period.
- Load condition: FIFO non-empty or crc_pending=1. crc_pending has priority over the FIFO.
- IDLE -> START on trigger_i when the load condition holds. The frame is loaded in that cycle:
  - a FIFO character is popped, or the CRC value is taken;
  - parity_mode_i and stop2_i are latched for the whole frame.
- START (tx_o=0) -> DATA. DATA shifts LSB-first, DATA_W bits. The bit counter ends at DATA_W-1, then the FSM goes to PARITY if parity is enabled, otherwise STOP1.
- PARITY: tx_o = XOR of the data bits for even parity, inverted for odd.
- STOP1 (tx_o=1) -> STOP2 if stop2 was latched, otherwise end of frame. STOP2 (tx_o=1) -> end of frame.
- End of frame (trigger that closes the final stop bit):
  - tx_int_o=1 for that single cycle;
  - if the load condition holds, load the next frame and go directly to START (no idle gap);
  - otherwise go to IDLE.
- CRC: on each FIFO pop the CRC register is updated with the popped data, MSB-first.
  - If the popped entry has last=1 and crc_en_i=1 (sampled at that pop), the updated CRC value is captured for transmission, crc_pending=1, and the CRC register is cleared to init.
  - If last=1 and crc_en_i=0, the CRC register is cleared and no CRC character is sent.
- The CRC character is framed like any other character (same parity/stop rules, latched at its own load) and clears crc_pending when loaded.
- trigger_i asserted continuously is legal: one bit per cycle.
- Config changes mid-frame have no effect until the next load.

Test Plan:
- DATA_W=8, parity 00, stop2=0, push 0xA5 (last=0) -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, one bit per trigger; tx_int_o pulses once; busy_o drops after that pulse.
- parity 01, stop2=1, push 0x07 -> start, bits 1,1,1,0,0,0,0,0, parity 1, stop 1, stop 1; same push with parity 10 gives parity 0.
- crc_en_i=1, push ASCII "123456789" (0x31..0x39), last=1 on 0x39 -> ten frames; the tenth carries 0xF4; exactly 10 tx_int_o pulses; CRC register is 0 afterwards.
- Push 0x01 with last=1 and crc_en_i=1 -> second frame carries 0x07. Repeat with crc_en_i=0 -> single frame only.
- Hold valid_i with 6 characters, FIFO_DEPTH=4, while idle with no trigger_i -> ready_o=0 at level 4. Drain -> frames are back-to-back with no idle high between the final stop and the next start; all 6 characters are sent in order.
- Assert rst_i=0 in the middle of DATA of the second of 3 queued characters -> tx_o=1 and fifo_level_o=0 immediately. After release with no pushes -> no further frames, busy_o=0.
